// File: rtl/spi_pkg.sv
// Shared SPI definitions for the team's SPI master and slave endpoints.
package spi_pkg;

    typedef enum logic [1:0] {
        StWaitDesel,
        StIdle,
        StActive
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int unsigned DEFAULT_DATA_W = 8;

    // Conventional SPI mode number: mode = {CPOL, CPHA}.
    function automatic spi_mode_t spi_mode(input int unsigned mode);
        spi_mode_t m;
        m.cpol = mode[1];
        m.cpha = mode[0];
        return m;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module spi_sync #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled SCLK/CS_n/MOSI, MSB-first word deserializer and
// MISO serializer fed from a one-word TX holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W  = DEFAULT_DATA_W,
    parameter bit                CPOL    = 1'b0,
    parameter bit                CPHA    = 1'b0,
    parameter logic [DATA_W-1:0] TX_IDLE = '1
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_spi_clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun
);

    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam spi_mode_t       MODE     = '{cpol: CPOL, cpha: CPHA};

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_dly_q, cs_n_dly_q;

    // CS_n resets to "selected" so a transaction in flight at reset is never joined mid-word.
    spi_sync #(.WIDTH(1), .RESET_VAL(CPOL)) u_sync_sclk (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .i_d   (i_spi_clk),
        .o_q   (sclk_s)
    );

    spi_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_cs_n (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .i_d   (i_spi_cs_n),
        .o_q   (cs_n_s)
    );

    spi_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .i_d   (i_spi_mosi),
        .o_q   (mosi_s)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_dly_q <= CPOL;
            cs_n_dly_q <= 1'b0;
        end else begin
            sclk_dly_q <= sclk_s;
            cs_n_dly_q <= cs_n_s;
        end
    end

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise;

    assign sclk_edge   = sclk_s ^ sclk_dly_q;
    assign lead_edge   = sclk_edge & (sclk_dly_q == MODE.cpol);
    assign trail_edge  = sclk_edge & (sclk_dly_q != MODE.cpol);
    assign sample_edge = MODE.cpha ? trail_edge : lead_edge;
    assign shift_edge  = MODE.cpha ? lead_edge : trail_edge;
    assign cs_fall     = cs_n_dly_q & ~cs_n_s;
    assign cs_rise     = ~cs_n_dly_q & cs_n_s;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              load_pend_q, load_pend_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              underrun_q, underrun_d;

    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] rx_word;
    logic              load;

    assign tx_word = hold_full_q ? hold_q : TX_IDLE;
    assign rx_word = {rx_shift_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        load_pend_d = load_pend_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            StWaitDesel: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StActive;
                    cnt_d     = '0;
                    miso_oe_d = 1'b1;
                    // CPHA=1 defers the load to the first shift edge of the word.
                    if (!MODE.cpha) begin
                        load        = 1'b1;
                        miso_d      = tx_word[DATA_W-1];
                        tx_shift_d  = tx_word << 1;
                        load_pend_d = 1'b0;
                    end else begin
                        miso_d      = 1'b0;
                        load_pend_d = 1'b1;
                    end
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_d = rx_word[DATA_W-2:0];
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        rx_data_d   = rx_word;
                        rx_valid_d  = 1'b1;
                        load_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (load_pend_q) begin
                        load        = 1'b1;
                        miso_d      = tx_word[DATA_W-1];
                        tx_shift_d  = tx_word << 1;
                        load_pend_d = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = StWaitDesel;
            end
        endcase

        // A load always sees the pre-handshake holding state.
        if (load) begin
            underrun_d  = ~hold_full_q;
            hold_full_d = 1'b0;
        end
        if (i_tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = i_tx_data;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitDesel;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            load_pend_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            load_pend_q <= load_pend_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = miso_oe_q;
    assign o_tx_ready    = ~hold_full_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, driven by a behavioural SPI master.
module tb_spi_slave;

    localparam int         W         = 8;
    localparam logic [7:0] IDLE_WORD = 8'hFF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sclk, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, underrun;
    logic [7:0] tx_data [4];
    logic [7:0] rx_data [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_log [4][64];
    int         rx_cnt [4];
    int         ur_cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .DATA_W  (W),
            .CPOL    (bit'(g / 2)),
            .CPHA    (bit'(g % 2)),
            .TX_IDLE (IDLE_WORD)
        ) u_dut (
            .i_clk         (clk),
            .rst_n         (rst_n),
            .i_spi_clk     (sclk[g]),
            .i_spi_cs_n    (cs_n[g]),
            .i_spi_mosi    (mosi[g]),
            .o_spi_miso    (miso[g]),
            .o_spi_miso_oe (miso_oe[g]),
            .i_tx_data     (tx_data[g]),
            .i_tx_valid    (tx_valid[g]),
            .o_tx_ready    (tx_ready[g]),
            .o_rx_data     (rx_data[g]),
            .o_rx_valid    (rx_valid[g]),
            .o_tx_underrun (underrun[g])
        );
    end

    // Record every RX word and underrun pulse, sampled away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_valid[g]) begin
                rx_log[g][rx_cnt[g] % 64] = rx_data[g];
                rx_cnt[g]++;
            end
            if (underrun[g]) ur_cnt[g]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half_bit();
        repeat (5) @(negedge clk);
    endtask

    // SPI master: shifts out nbits of data MSB-first, returns the captured MISO bits.
    task automatic xfer(input int m, input logic [31:0] data, input int nbits,
                        input bit keep_cs, output logic [31:0] out);
        bit cpol, cpha;
        cpol = bit'(m / 2);
        cpha = bit'(m % 2);
        out  = '0;
        @(negedge clk);
        cs_n[m] = 1'b0;
        if (!cpha) mosi[m] = data[nbits-1];
        half_bit();
        for (int i = 0; i < nbits; i++) begin
            if (cpha) begin
                sclk[m] = ~cpol;
                mosi[m] = data[nbits-1-i];
                half_bit();
                sclk[m] = cpol;
                out     = {out[30:0], miso[m]};
                half_bit();
            end else begin
                sclk[m] = ~cpol;
                out     = {out[30:0], miso[m]};
                half_bit();
                sclk[m] = cpol;
                if (i < nbits - 1) mosi[m] = data[nbits-2-i];
                half_bit();
            end
        end
        if (!keep_cs) begin
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
            half_bit();
            half_bit();
        end
    endtask

    // Offers words to the holding register one at a time, waiting (bounded) for ready.
    task automatic feed(input int m, input int ntx, input logic [7:0] txw [4], input string tag);
        for (int k = 0; k < ntx; k++) begin
            int t = 0;
            while (!tx_ready[m] && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("%s_ready_wait%0d", tag, k), 32'(tx_ready[m]), 32'd1);
            tx_data[m]  = txw[k];
            tx_valid[m] = 1'b1;
            @(negedge clk);
            tx_valid[m] = 1'b0;
        end
    endtask

    // Reference: every complete word is received in order; each TX load takes the next
    // supplied word or the idle word. CPHA=0 loads at select and after every word,
    // CPHA=1 loads once at the start of every word.
    task automatic run_txn(input int m, input int n, input logic [7:0] rxw [4], input int ntx,
                           input logic [7:0] txw [4], input string tag);
        int          rx0, ur0, nloads;
        logic [31:0] stream, out;
        logic [7:0]  exp_tx;
        rx0    = rx_cnt[m];
        ur0    = ur_cnt[m];
        stream = '0;
        for (int k = 0; k < n; k++) stream = (stream << 8) | 32'(rxw[k]);
        fork
            xfer(m, stream, 8 * n, 1'b0, out);
            feed(m, ntx, txw, tag);
        join
        repeat (10) @(negedge clk);
        nloads = (m % 2 == 1) ? n : n + 1;
        check({tag, "_rxcnt"}, 32'(rx_cnt[m] - rx0), 32'(n));
        for (int k = 0; k < n; k++) begin
            exp_tx = (k < ntx) ? txw[k] : IDLE_WORD;
            check($sformatf("%s_rx%0d", tag, k), 32'(rx_log[m][(rx0 + k) % 64]), 32'(rxw[k]));
            check($sformatf("%s_miso%0d", tag, k), 32'(out[(n-1-k)*8 +: 8]), 32'(exp_tx));
        end
        check({tag, "_underruns"}, 32'(ur_cnt[m] - ur0), 32'(nloads - ntx));
        check({tag, "_ready"}, 32'(tx_ready[m]), 32'd1);
        check({tag, "_oe"}, 32'(miso_oe[m]), 32'd0);
    endtask

    task automatic check_reset(input int m, input string tag);
        check({tag, "_miso"}, 32'(miso[m]), 32'd0);
        check({tag, "_oe"}, 32'(miso_oe[m]), 32'd0);
        check({tag, "_ready"}, 32'(tx_ready[m]), 32'd1);
        check({tag, "_rxdata"}, 32'(rx_data[m]), 32'd0);
        check({tag, "_rxvalid"}, 32'(rx_valid[m]), 32'd0);
        check({tag, "_underrun"}, 32'(underrun[m]), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rxw [4];
        logic [7:0]  txw [4];
        logic [31:0] out;
        int          rx0, ur0, m, n, ntx;

        sclk     = 4'b1100;
        cs_n     = 4'b1111;
        mosi     = 4'b0000;
        tx_valid = 4'b0000;
        for (int g = 0; g < 4; g++) tx_data[g] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            rxw[k] = 8'h00;
            txw[k] = 8'h00;
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) check_reset(g, $sformatf("rst%0d", g));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0 single word with a preloaded holding register.
        rxw[0] = 8'hA5;
        txw[0] = 8'h3C;
        run_txn(0, 1, rxw, 1, txw, "m0_basic");
        check("m0_rxdata_held", 32'(rx_data[0]), 32'hA5);

        // Back-to-back words; CPHA=0 modes get one extra word for the post-word load.
        rxw[0] = 8'h81; rxw[1] = 8'h7E;
        txw[0] = 8'h55; txw[1] = 8'hAA; txw[2] = 8'h00;
        run_txn(1, 2, rxw, 2, txw, "m1_b2b");
        run_txn(2, 2, rxw, 3, txw, "m2_b2b");
        run_txn(3, 2, rxw, 2, txw, "m3_b2b");

        // No TX data: idle word and a single underrun pulse.
        rxw[0] = 8'h3E;
        run_txn(1, 1, rxw, 0, txw, "m1_underrun");

        // Abort after 5 bits of 0xF0, then a clean word.
        rx0 = rx_cnt[0];
        xfer(0, 32'h1E, 5, 1'b0, out);
        repeat (10) @(negedge clk);
        check("abort_rxcnt", 32'(rx_cnt[0] - rx0), 32'd0);
        check("abort_oe", 32'(miso_oe[0]), 32'd0);
        rxw[0] = 8'h12;
        run_txn(0, 1, rxw, 0, txw, "after_abort");

        // Reset mid-word with CS_n held low.
        xfer(0, 32'h5, 3, 1'b1, out);
        check("midword_oe", 32'(miso_oe[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset(0, "rst_mid");
        rst_n = 1'b1;
        rx0 = rx_cnt[0];
        ur0 = ur_cnt[0];
        xfer(0, 32'hC3, 8, 1'b0, out);
        repeat (10) @(negedge clk);
        check("postrst_rxcnt", 32'(rx_cnt[0] - rx0), 32'd0);
        check("postrst_ur", 32'(ur_cnt[0] - ur0), 32'd0);
        check("postrst_oe", 32'(miso_oe[0]), 32'd0);
        rxw[0] = 8'h6D;
        txw[0] = 8'h5A;
        run_txn(0, 1, rxw, 1, txw, "after_rst");

        // Handshake coincident with the CS_n-fall load (3rd clock edge after the pin).
        rx0 = rx_cnt[0];
        ur0 = ur_cnt[0];
        fork
            xfer(0, 32'h0000_C0DE, 16, 1'b0, out);
            begin
                @(negedge clk);
                repeat (2) @(negedge clk);
                tx_data[0]  = 8'h99;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("same_cyc_w0", 32'(out[15:8]), 32'(IDLE_WORD));
        check("same_cyc_w1", 32'(out[7:0]), 32'h99);
        check("same_cyc_ur", 32'(ur_cnt[0] - ur0), 32'd2);
        check("same_cyc_rx0", 32'(rx_log[0][rx0 % 64]), 32'hC0);
        check("same_cyc_rx1", 32'(rx_log[0][(rx0 + 1) % 64]), 32'hDE);

        // Randomized transactions across all modes.
        for (int r = 0; r < 12; r++) begin
            m   = int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 3));
            ntx = int'($urandom_range(0, n));
            for (int k = 0; k < 4; k++) begin
                rxw[k] = 8'($urandom);
                txw[k] = 8'($urandom);
            end
            run_txn(m, n, rxw, ntx, txw, $sformatf("rand%0d_m%0d", r, m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
